// File: rtl/soin_bpredictor_update_queue.sv
// Branch-predictor update queue: buffers resolved branches, computes saturated 2-bit counters and issues one table/BTB write per cycle.
// Optional feature: define BP_UPD_BYPASS_EN to forward the last written counter byte into back-to-back updates of the same byte.
`timescale 1ns/1ps

`ifndef BP_META_WIDTH
`define BP_META_WIDTH 18
`endif

module soin_bpredictor_update_queue #(
  parameter int unsigned DEPTH_L = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      execute_bpredictor_update,
  input  logic [31:0]               execute_bpredictor_PC,
  input  logic [31:0]               execute_bpredictor_target,
  input  logic                      execute_bpredictor_dir,
  input  logic                      execute_bpredictor_miss,
  input  logic [`BP_META_WIDTH-1:0] execute_bpredictor_meta,
  input  logic                      up_ready,
  output logic                      up_wen,
  output logic [7:0]                up_index,
  output logic [31:0]               up_data,
  output logic [3:0]                up_be,
  output logic                      up_target_wen,
  output logic [29:0]               up_target,
  output logic                      queue_full,
  output logic [15:0]               drop_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_L;

  typedef struct packed {
    logic [7:0]  index;
    logic [7:0]  cbyte;
    logic [1:0]  lane;
    logic [1:0]  k;
    logic        dir;
    logic        miss;
    logic [29:0] target;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  entry_t           in_entry;
  logic [DEPTH_L:0] rd_ptr;
  logic [DEPTH_L:0] wr_ptr;
  logic             empty;
  logic             full;
  logic             deq;
  logic             enq;
  logic             drop;

  logic [7:0]       base_byte;
  logic [7:0]       new_byte;
  logic [1:0]       old_cnt;
  logic [1:0]       new_cnt;
  logic             need_wen;
  logic             need_twen;

  // Only PC[3:2], target[31:2] and meta[17:0] carry information for this block.
  logic unused_bits;
  assign unused_bits = ^{execute_bpredictor_PC[31:4], execute_bpredictor_PC[1:0],
                         execute_bpredictor_target[1:0]};

  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[DEPTH_L] != wr_ptr[DEPTH_L]) &&
                 (rd_ptr[DEPTH_L-1:0] == wr_ptr[DEPTH_L-1:0]);
  assign deq   = !empty && up_ready;
  assign enq   = execute_bpredictor_update && (!full || deq);
  assign drop  = execute_bpredictor_update && full && !deq;

  assign queue_full = full;
  assign head       = mem[rd_ptr[DEPTH_L-1:0]];

  always_comb begin
    in_entry        = '0;
    in_entry.index  = execute_bpredictor_meta[7:0];
    in_entry.cbyte  = execute_bpredictor_meta[15:8];
    in_entry.lane   = execute_bpredictor_meta[17:16];
    in_entry.k      = execute_bpredictor_PC[3:2];
    in_entry.dir    = execute_bpredictor_dir;
    in_entry.miss   = execute_bpredictor_miss;
    in_entry.target = execute_bpredictor_target[31:2];
  end

  // Storage needs no reset: clearing the pointers discards every entry.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr[DEPTH_L-1:0]] <= in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      drop_count <= '0;
    end else begin
      if (deq) rd_ptr <= rd_ptr + {{DEPTH_L{1'b0}}, 1'b1};
      if (enq) wr_ptr <= wr_ptr + {{DEPTH_L{1'b0}}, 1'b1};
      if (drop && (drop_count != '1)) drop_count <= drop_count + 16'd1;
    end
  end

`ifdef BP_UPD_BYPASS_EN
  logic       lw_valid;
  logic [7:0] lw_index;
  logic [1:0] lw_lane;
  logic [7:0] lw_byte;

  always_ff @(posedge clk) begin
    if (!reset) begin
      lw_valid <= 1'b0;
      lw_index <= '0;
      lw_lane  <= '0;
      lw_byte  <= '0;
    end else if (deq && need_wen) begin
      lw_valid <= 1'b1;
      lw_index <= head.index;
      lw_lane  <= head.lane;
      lw_byte  <= new_byte;
    end
  end

  // The meta byte was read before the previous write landed; use the written value instead.
  always_comb begin
    base_byte = head.cbyte;
    if (lw_valid && (lw_index == head.index) && (lw_lane == head.lane)) begin
      base_byte = lw_byte;
    end
  end
`else
  assign base_byte = head.cbyte;
`endif

  always_comb begin
    old_cnt = base_byte[{head.k, 1'b0} +: 2];
    new_cnt = old_cnt;
    if (head.dir) begin
      if (old_cnt != 2'd3) new_cnt = old_cnt + 2'd1;
    end else begin
      if (old_cnt != 2'd0) new_cnt = old_cnt - 2'd1;
    end
    new_byte = base_byte;
    new_byte[{head.k, 1'b0} +: 2] = new_cnt;
    need_wen  = (new_byte != base_byte);
    need_twen = head.dir && head.miss;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      up_wen        <= 1'b0;
      up_target_wen <= 1'b0;
      up_index      <= '0;
      up_data       <= '0;
      up_be         <= '0;
      up_target     <= '0;
    end else begin
      up_wen        <= deq && need_wen;
      up_target_wen <= deq && need_twen;
      if (deq) begin
        up_index  <= head.index;
        up_data   <= {4{new_byte}};
        up_be     <= 4'b0001 << head.lane;
        up_target <= head.target;
      end
    end
  end

endmodule

// File: tb/tb_soin_bpredictor_update_queue.sv
// Self-checking bench for soin_bpredictor_update_queue: vector table, scoreboard of expected writes, and hand sequences for full/drop, bypass and reset.
`timescale 1ns/1ps

`ifndef BP_META_WIDTH
`define BP_META_WIDTH 18
`endif

module tb_soin_bpredictor_update_queue;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic                      update = 1'b0;
  logic [31:0]               pc = '0;
  logic [31:0]               target = '0;
  logic                      dir = 1'b0;
  logic                      miss = 1'b0;
  logic [`BP_META_WIDTH-1:0] meta = '0;
  logic                      up_ready = 1'b1;
  logic                      up_wen;
  logic [7:0]                up_index;
  logic [31:0]               up_data;
  logic [3:0]                up_be;
  logic                      up_target_wen;
  logic [29:0]               up_target;
  logic                      queue_full;
  logic [15:0]               drop_count;

  soin_bpredictor_update_queue #(.DEPTH_L(2)) dut (
    .clk                       (clk),
    .reset                     (reset),
    .execute_bpredictor_update (update),
    .execute_bpredictor_PC     (pc),
    .execute_bpredictor_target (target),
    .execute_bpredictor_dir    (dir),
    .execute_bpredictor_miss   (miss),
    .execute_bpredictor_meta   (meta),
    .up_ready                  (up_ready),
    .up_wen                    (up_wen),
    .up_index                  (up_index),
    .up_data                   (up_data),
    .up_be                     (up_be),
    .up_target_wen             (up_target_wen),
    .up_target                 (up_target),
    .queue_full                (queue_full),
    .drop_count                (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  index;
    logic [7:0]  cbyte;
    logic [1:0]  lane;
    logic [1:0]  k;
    logic        dir;
    logic        miss;
    logic [31:0] target;
    logic        exp_wen;
    logic        exp_twen;
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    logic [29:0] exp_target;
  } vec_t;

  typedef struct {
    logic        wen;
    logic        twen;
    logic [7:0]  index;
    logic [31:0] data;
    logic [3:0]  be;
    logic [29:0] target;
  } wr_t;

  wr_t sb[$];
  int  tests = 0;
  int  fails = 0;
  int  wr_seen = 0;
  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent reference: saturating update of field k in a counter byte.
  function automatic vec_t mk(input logic [7:0] index, input logic [7:0] cbyte,
                              input logic [1:0] lane, input logic [1:0] k,
                              input logic dir, input logic miss, input logic [31:0] tgt);
    vec_t v;
    int   old, nw, nb, sh;
    sh  = 2 * int'(k);
    old = (int'(cbyte) >> sh) & 3;
    if (dir) nw = (old == 3) ? 3 : old + 1;
    else     nw = (old == 0) ? 0 : old - 1;
    nb  = (int'(cbyte) & ~(3 << sh)) | (nw << sh);
    v.index = index; v.cbyte = cbyte; v.lane = lane; v.k = k;
    v.dir = dir; v.miss = miss; v.target = tgt;
    v.exp_wen    = (nb != int'(cbyte));
    v.exp_twen   = dir && miss;
    v.exp_data   = {4{nb[7:0]}};
    v.exp_be     = 4'(1 << int'(lane));
    v.exp_target = tgt[31:2];
    return v;
  endfunction

  task automatic push(input vec_t v);
    if (v.exp_wen || v.exp_twen)
      sb.push_back('{v.exp_wen, v.exp_twen, v.index, v.exp_data, v.exp_be, v.exp_target});
  endtask

  task automatic send(input vec_t v);
    update = 1'b1;
    pc = $urandom;
    pc[3:2] = v.k;
    target = v.target;
    dir = v.dir;
    miss = v.miss;
    meta = '0;
    meta[7:0] = v.index;
    meta[15:8] = v.cbyte;
    meta[17:16] = v.lane;
    @(posedge clk); #1;
    update = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_wen"}, 32'(up_wen), 32'h0);
    chk({tag, "_twen"}, 32'(up_target_wen), 32'h0);
    chk({tag, "_index"}, 32'(up_index), 32'h0);
    chk({tag, "_data"}, up_data, 32'h0);
    chk({tag, "_be"}, 32'(up_be), 32'h0);
    chk({tag, "_target"}, 32'(up_target), 32'h0);
    chk({tag, "_full"}, 32'(queue_full), 32'h0);
    chk({tag, "_drop"}, 32'(drop_count), 32'h0);
  endtask

  task automatic do_reset();
    sb.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset && (up_wen || up_target_wen)) begin
      wr_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_write", {up_index, 22'h0, up_wen, up_target_wen}, 32'h0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("wr_wen", 32'(up_wen), 32'(e.wen));
        chk("wr_twen", 32'(up_target_wen), 32'(e.twen));
        chk("wr_index", 32'(up_index), 32'(e.index));
        chk("wr_data", up_data, e.data);
        chk("wr_be", 32'(up_be), 32'(e.be));
        chk("wr_target", 32'(up_target), 32'(e.target));
      end
    end
  end

  initial begin
    vec_t v;

    //      index  byte   ln  k   dir  miss target         wen  twen data           be       target
    vt[0] = '{8'h12, 8'h00, 2'd2, 2'd1, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h04040404, 4'b0100, 30'h0};
    vt[1] = '{8'h20, 8'hFF, 2'd0, 2'd0, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'hFFFFFFFF, 4'b0001, 30'h0};
    vt[2] = '{8'h21, 8'h00, 2'd1, 2'd2, 1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h00000000, 4'b0010, 30'h0};
    vt[3] = '{8'h22, 8'h00, 2'd3, 2'd0, 1'b1, 1'b1, 32'h0000_1234, 1'b1, 1'b1, 32'h01010101, 4'b1000, 30'h48D};
    vt[4] = '{8'h23, 8'hFF, 2'd0, 2'd3, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'hFFFFFFFF, 4'b0001, 30'h37AB6FBB};
    vt[5] = '{8'h24, 8'hB4, 2'd1, 2'd2, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'hA4A4A4A4, 4'b0010, 30'h0};
    vt[6] = '{8'h25, 8'h80, 2'd2, 2'd3, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'hC0C0C0C0, 4'b0100, 30'h0};
    vt[7] = '{8'h26, 8'h0C, 2'd3, 2'd1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'h08080808, 4'b1000, 30'h0};
    vt[8] = '{8'h27, 8'h00, 2'd0, 2'd0, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h00000000, 4'b0001, 30'h0};

    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;

    // Two-cycle latency from sampling edge to strobe.
    up_ready = 1'b1;
    push(vt[0]);
    send(vt[0]);
    chk("latency_n1_wen", 32'(up_wen), 32'h0);
    @(posedge clk); #1;
    chk("latency_n2_wen", 32'(up_wen), 32'h1);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back vectors at one update per cycle; distinct indices keep bypass out of play.
    for (int i = 0; i < 9; i++) begin
      push(vt[i]);
      send(vt[i]);
    end
    repeat (6) @(posedge clk);
    #1;
    chk("table_drained", 32'(sb.size()), 32'h0);

    // Fill with up_ready low; the fifth update is dropped.
    up_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      v = mk(8'h40 + 8'(i), 8'h00, 2'(i), 2'd0, 1'b1, 1'b0, 32'h0);
      if (i < 4) push(v);
      send(v);
      chk($sformatf("fill%0d_full", i), 32'(queue_full), 32'(i >= 3));
    end
    chk("drop_after_5", 32'(drop_count), 32'h1);
    chk("frozen_no_wen", 32'(up_wen), 32'h0);

    // Enqueue and dequeue in the same cycle while full: accepted, still full, no drop.
    up_ready = 1'b1;
    v = mk(8'h50, 8'h02, 2'd1, 2'd0, 1'b0, 1'b0, 32'h0);
    push(v);
    send(v);
    chk("full_enq_deq_full", 32'(queue_full), 32'h1);
    chk("full_enq_deq_drop", 32'(drop_count), 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_wen", i), 32'(up_wen), 32'h1);
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drained_full", 32'(queue_full), 32'h0);
    chk("drained_sb", 32'(sb.size()), 32'h0);

    // Back-to-back increments of the same counter byte.
    do_reset();
    up_ready = 1'b1;
    v = mk(8'h03, 8'h01, 2'd0, 2'd0, 1'b1, 1'b0, 32'h0);
    sb.push_back('{1'b1, 1'b0, 8'h03, 32'h02020202, 4'b0001, 30'h0});
`ifdef BP_UPD_BYPASS_EN
    sb.push_back('{1'b1, 1'b0, 8'h03, 32'h03030303, 4'b0001, 30'h0});
`else
    sb.push_back('{1'b1, 1'b0, 8'h03, 32'h02020202, 4'b0001, 30'h0});
`endif
    send(v);
    send(v);
    repeat (4) @(posedge clk);
    #1;
    chk("bypass_sb", 32'(sb.size()), 32'h0);

    // Reset with a full queue and a dropped update outstanding.
    up_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(mk(8'h60 + 8'(i), 8'h00, 2'(i), 2'd1, 1'b1, 1'b1, 32'h0000_4000));
    end
    chk("pre_reset_full", 32'(queue_full), 32'h1);
    chk("pre_reset_drop", 32'(drop_count), 32'h1);
    sb.delete();
    reset = 1'b0;
    @(posedge clk); #1;
    check_zero("midreset");
    reset = 1'b1;
    up_ready = 1'b1;
    wr_seen = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_reset_writes", 32'(wr_seen), 32'h0);
    chk("post_reset_full", 32'(queue_full), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
